// File: rtl/keyb_event_queue.sv
// keyb_event_queue
//   Sits behind the keypad column scanner. It debounces the scanner's
//   {btn_pressed, btn_out} pair and decodes the one-hot column/row byte to a
//   4-bit key code (row*4 + col). It emits one event per physical press into a
//   small show-ahead FIFO that is read over a valid/ready handshake.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   btn_pressed  scanner key-present flag
//   btn_out      scanner key id: [7:4] one-hot column, [3:0] one-hot row
//   key_valid    FIFO not empty, key_code is valid
//   key_code     FIFO head (show-ahead); holds the last head while empty
//   key_ready    consumer pop, taken when key_valid && key_ready
//   key_held     high while a key is held or its release is being debounced
//   fifo_count   entries currently stored
//   overflow     sticky: an accepted press was dropped on a full FIFO
//   clr_ovf      synchronous clear of overflow (a same-edge drop wins)
module keyb_event_queue #(
  parameter int STABLE_CYCLES = 16,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     btn_pressed,
  input  logic [7:0]               btn_out,
  output logic                     key_valid,
  output logic [3:0]               key_code,
  input  logic                     key_ready,
  output logic                     key_held,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [7:0]    CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0]    CNT_LAST = 8'(STABLE_CYCLES - 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  function automatic logic is_onehot4(input logic [3:0] n);
    return (n != 4'd0) && ((n & (n - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] enc4(input logic [3:0] n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  state_t          state_q, state_d;
  logic [8:0]      smp_q, smp_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      head_q, head_d;
  logic            ovf_q, ovf_d;

  logic [8:0]      inp;
  logic            same;
  logic            stable;
  logic            valid_press;
  logic [3:0]      press_code;
  logic            push_req;
  logic            empty;
  logic            full;
  logic            pop;
  logic            do_push;
  logic            drop;

  assign inp         = {btn_pressed, btn_out};
  assign same        = (inp == smp_q);
  // cnt_q counts edges beyond the first that saw the current value, so the
  // edge where it equals STABLE_CYCLES-2 is the STABLE_CYCLES-th identical one.
  assign stable      = same && (cnt_q == CNT_LAST);
  assign valid_press = btn_pressed && is_onehot4(btn_out[7:4]) && is_onehot4(btn_out[3:0]);
  assign press_code  = {enc4(btn_out[3:0]), enc4(btn_out[7:4])};

  always_comb begin
    smp_d = inp;
    if (same) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd0;
    end
  end

  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_press) state_d = PRESS_DB;
      end
      PRESS_DB: begin
        if (!valid_press) begin
          state_d = IDLE;
        end else if (stable) begin
          push_req = 1'b1;
          state_d  = HELD;
        end
      end
      HELD: begin
        // Only a release matters here; a different key is ignored.
        if (!btn_pressed) state_d = REL_DB;
      end
      REL_DB: begin
        if (btn_pressed) begin
          state_d = HELD;
        end else if (stable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign pop     = !empty && key_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign do_push = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({do_push, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase

    // The head register keeps key_code defined and stable while empty.
    head_d = head_q;
    if (do_push && (empty || (pop && count_q == ONE_CNT))) begin
      head_d = press_code;
    end else if (pop && count_q > ONE_CNT) begin
      head_d = mem_q[rd_ptr_q + PW'(1)];
    end

    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      smp_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      smp_q    <= smp_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries data only; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= press_code;
  end

  assign key_valid  = !empty;
  assign key_code   = head_q;
  assign key_held   = (state_q == HELD) || (state_q == REL_DB);
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_keyb_event_queue.sv
module tb_keyb_event_queue;

  localparam int S = 16;
  localparam int D = 4;

  localparam int M_IDLE  = 0;
  localparam int M_PRESS = 1;
  localparam int M_HELD  = 2;
  localparam int M_REL   = 3;

  logic                 clk;
  logic                 reset;
  logic                 btn_pressed;
  logic [7:0]           btn_out;
  logic                 key_valid;
  logic [3:0]           key_code;
  logic                 key_ready;
  logic                 key_held;
  logic [$clog2(D):0]   fifo_count;
  logic                 overflow;
  logic                 clr_ovf;

  int n_cmp = 0;
  int n_err = 0;

  keyb_event_queue #(.STABLE_CYCLES(S), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_pressed(btn_pressed),
    .btn_out    (btn_out),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .key_held   (key_held),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [8:0] m_prev = '0;
  int         m_run  = 1;
  int         m_st   = M_IDLE;
  logic [3:0] m_q[$];
  logic       m_ovf  = 1'b0;
  logic [3:0] m_code = 4'd0;
  logic [8:0] m_inp;
  logic       m_stable, m_valid, m_push, m_drop;
  logic [3:0] m_kc;

  function automatic logic [3:0] code_of(input logic [7:0] bo);
    int col, row;
    col = 0;
    row = 0;
    for (int i = 0; i < 4; i++) begin
      if (bo[4+i]) col = i;
      if (bo[i])   row = i;
    end
    return 4'(row * 4 + col);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_prev = '0;
      m_run  = 1;
      m_st   = M_IDLE;
      m_q.delete();
      m_ovf  = 1'b0;
      m_code = 4'd0;
    end else begin
      m_inp = {btn_pressed, btn_out};
      if (m_inp == m_prev) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_run = 1;
      end
      m_prev   = m_inp;
      m_stable = (m_run == S);
      m_valid  = btn_pressed && ($countones(btn_out[7:4]) == 1) && ($countones(btn_out[3:0]) == 1);
      m_kc     = code_of(btn_out);
      m_push   = 1'b0;
      m_drop   = 1'b0;
      case (m_st)
        M_IDLE:  if (m_valid) m_st = M_PRESS;
        M_PRESS: begin
          if (!m_valid) m_st = M_IDLE;
          else if (m_stable) begin
            m_push = 1'b1;
            m_st   = M_HELD;
          end
        end
        M_HELD:  if (!btn_pressed) m_st = M_REL;
        default: begin
          if (btn_pressed) m_st = M_HELD;
          else if (m_stable) m_st = M_IDLE;
        end
      endcase
      if (key_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (m_push) begin
        if (m_q.size() < D) m_q.push_back(m_kc);
        else m_drop = 1'b1;
      end
      if (m_drop) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
      if (m_q.size() > 0) m_code = m_q[0];
    end
  end

  always @(posedge clk) begin
    #2;
    chk("cyc_valid", int'(key_valid), int'(m_q.size() != 0));
    chk("cyc_code", int'(key_code), int'(m_code));
    chk("cyc_held", int'(key_held), int'(m_st == M_HELD || m_st == M_REL));
    chk("cyc_count", int'(fifo_count), m_q.size());
    chk("cyc_ovf", int'(overflow), int'(m_ovf));
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic bp, input logic [7:0] bo);
    btn_pressed = bp;
    btn_out     = bo;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] bo_of(input int code);
    logic [3:0] c, r;
    c = 4'b0001 << (code % 4);
    r = 4'b0001 << (code / 4);
    return {c, r};
  endfunction

  task automatic pop_chk(input string nm, input int exp);
    chk(nm, int'(key_code), exp);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  // Input is applied at a falling edge; the next rising edge is N.
  // The event must appear after edge N+S-1 and not after edge N+S-2.
  task automatic lat_chk(input string nm, input int code);
    drive(1'b1, bo_of(code));
    repeat (S - 1) @(posedge clk);
    #2 chk({nm, "_early"}, int'(key_valid), 0);
    @(posedge clk);
    #2 chk({nm, "_push"}, int'(key_valid), 1);
    chk({nm, "_code"}, int'(key_code), code);
    @(negedge clk);
  endtask

  task automatic press_rel(input int code);
    drive(1'b1, bo_of(code));
    hold(20);
    drive(1'b0, 8'h00);
    hold(20);
  endtask

  int codes5[5] = '{0, 5, 10, 15, 3};

  initial begin
    reset       = 1'b0;
    btn_pressed = 1'b0;
    btn_out     = 8'h00;
    key_ready   = 1'b0;
    clr_ovf     = 1'b0;
    hold(3);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_code", int'(key_code), 0);
    chk("rst_held", int'(key_held), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_ovf", int'(overflow), 0);
    reset = 1'b1;
    hold(3);

    // single press, row 2 col 1
    lat_chk("t1", 9);
    hold(24);
    chk("t1_valid", int'(key_valid), 1);
    chk("t1_code", int'(key_code), 9);
    chk("t1_held", int'(key_held), 1);
    chk("t1_count", int'(fifo_count), 1);
    chk("t1_model_size", m_q.size(), 1);
    drive(1'b0, 8'h00);
    pop_chk("t1_pop", 9);
    hold(20);
    chk("t1_after_count", int'(fifo_count), 0);
    chk("t1_after_held", int'(key_held), 0);
    chk("t1_after_code", int'(key_code), 9);

    // bounce
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, bo_of(6));
      hold(5);
      drive(1'b0, 8'h00);
      hold(5);
    end
    hold(20);
    chk("t2_valid", int'(key_valid), 0);
    chk("t2_held", int'(key_held), 0);

    // ghost / multi-key patterns
    drive(1'b1, 8'b0011_0001);
    hold(40);
    chk("t3a_count", int'(fifo_count), 0);
    chk("t3a_held", int'(key_held), 0);
    drive(1'b1, 8'b0001_0011);
    hold(40);
    chk("t3b_count", int'(fifo_count), 0);
    chk("t3b_held", int'(key_held), 0);
    drive(1'b0, 8'h00);
    hold(20);

    // five presses into a 4-deep FIFO, no reads
    for (int i = 0; i < 5; i++) press_rel(codes5[i]);
    chk("t4_count", int'(fifo_count), 4);
    chk("t4_ovf", int'(overflow), 1);
    chk("t4_head", int'(key_code), 0);
    chk("t4_model_ovf", int'(m_ovf), 1);
    chk("t4_model_size", m_q.size(), 4);
    pop_chk("t4_pop0", 0);
    pop_chk("t4_pop1", 5);
    pop_chk("t4_pop2", 10);
    pop_chk("t4_pop3", 15);
    chk("t4_empty", int'(fifo_count), 0);
    chk("t4_ovf_kept", int'(overflow), 1);
    clr_ovf = 1'b1;
    hold(1);
    clr_ovf = 1'b0;
    chk("t4_clr", int'(overflow), 0);

    // full FIFO, pop on the same edge as the fifth push
    for (int i = 0; i < 4; i++) press_rel(codes5[i]);
    chk("t5_full", int'(fifo_count), 4);
    drive(1'b1, bo_of(3));
    repeat (S - 1) @(posedge clk);
    @(negedge clk);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    hold(4);
    drive(1'b0, 8'h00);
    hold(20);
    chk("t5_ovf", int'(overflow), 0);
    chk("t5_count", int'(fifo_count), 4);
    pop_chk("t5_pop0", 5);
    pop_chk("t5_pop1", 10);
    pop_chk("t5_pop2", 15);
    pop_chk("t5_pop3", 3);
    chk("t5_empty", int'(fifo_count), 0);

    // reset while held; the still-held key re-debounces
    drive(1'b1, bo_of(7));
    hold(20);
    chk("t6_count", int'(fifo_count), 1);
    chk("t6_held", int'(key_held), 1);
    #3 reset = 1'b0;
    #1;
    chk("t6_rst_valid", int'(key_valid), 0);
    chk("t6_rst_code", int'(key_code), 0);
    chk("t6_rst_held", int'(key_held), 0);
    chk("t6_rst_count", int'(fifo_count), 0);
    chk("t6_rst_ovf", int'(overflow), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (S - 1) @(posedge clk);
    #2 chk("t6_early", int'(key_valid), 0);
    @(posedge clk);
    #2 chk("t6_push", int'(key_valid), 1);
    chk("t6_code", int'(key_code), 7);
    chk("t6_held2", int'(key_held), 1);
    @(negedge clk);
    drive(1'b0, 8'h00);
    hold(20);
    pop_chk("t6_pop", 7);
    hold(2);

    // randomized traffic against the model
    for (int seg = 0; seg < 250; seg++) begin
      int sel, n;
      sel = $urandom_range(0, 99);
      if (sel < 50)      drive(1'b1, bo_of($urandom_range(0, 15)));
      else if (sel < 75) drive(1'b0, 8'($urandom_range(0, 255)));
      else               drive(1'b1, 8'($urandom_range(0, 255)));
      n = $urandom_range(1, 30);
      for (int j = 0; j < n; j++) begin
        key_ready = ($urandom_range(0, 3) == 0);
        clr_ovf   = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
    end
    key_ready = 1'b0;
    clr_ovf   = 1'b0;
    drive(1'b0, 8'h00);
    hold(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
